mul_pipe: RTL and testbench
===========================

# mul_pipe

Parametrised, two-stage pipelined radix-4 Booth / Wallace-tree multiplier with a valid/ready handshake and a signed/unsigned mode. It generalises the fixed 17-row compressor slice. Recoding, partial-product generation, the full compressor tree and the final carry-propagate add all live inside this block. It sits in the execute path: the issue stage feeds operands, and the writeback stage consumes the 2×WIDTH-bit product plus an opaque tag.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 8.
- TAG_W, 5, width of the sideband tag carried alongside each operation.

- mul_clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  cancel all in-flight operations this cycle.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- out_prod  out  2*WIDTH  full product.
- out_tag  out  TAG_W  tag of the product on out_prod.

## Operation
- **Operand extension:** each operand is extended to WIDTH+2 bits, sign-extended if in_signed=1, zero-extended otherwise.
- **Partial products:** radix-4 Booth recoding of extended in_b gives WIDTH/2+1 partial products. Negative rows use the invert-plus-correction-bit form and sign-extension-prevention constants. No row is truncated below 2*WIDTH bits.
- **Stage M1 (combinational in the cycle operands are accepted):** recode, generate partial products, and run the Wallace 3:2 compressor levels until ≤ 4 rows remain. Register the rows, in_tag and m1_valid.
- **Stage M2:** finish compression to 2 rows and add them with a 2*WIDTH-bit adder. Register the result (modulo 2^(2*WIDTH)), the tag and m2_valid. out_prod and out_tag are driven directly from the M2 registers.
- **Result:** out_prod is the exact 2*WIDTH-bit product of the interpreted operands. Signed results are in two's complement.
- **Handshake:**
  - m2_allowin = !m2_valid | out_ready
  - m1_allowin = !m1_valid | m2_allowin
  - in_ready = m1_allowin & !flush
  - Accept on in_valid & in_ready. M1→M2 transfer on m1_valid & m2_allowin. Output consumed on out_valid & out_ready.
- **Stalls:** each stage holds its data and valid while its downstream is stalled. No bubbles are inserted: sustained throughput is 1 op/cycle when out_ready=1.
- **Flush:**
  - In the flush cycle, out_valid is forced 0 and in_ready is 0.
  - At the next edge, m1_valid and m2_valid clear and nothing is accepted.
  - Data registers may keep stale values.
  - An out_ready asserted during the flush cycle consumes nothing.
- **Reset:** every valid bit and data register goes to 0 at the edge. reset overrides flush and handshakes.

## Timing
- **Reset values:** out_valid=0, out_prod=0, out_tag=0. in_ready=1 in the first cycle after reset if flush=0.
- **Latency:** operands accepted at edge k produce out_valid=1 with the correct out_prod/out_tag in the cycle after edge k+1 (2 cycles), provided out_ready did not stall M2.
- **Output stability:** while out_valid=1 and out_ready=0, out_prod and out_tag stay stable.
- **Full pipeline, out_ready=0:** both stages valid, in_ready=0. The first out_ready=1 cycle frees one slot, so in_ready=1 in that same cycle (combinational pass-through), with no lost or duplicated operation.
- **Simultaneous output and input:** output consumption and new acceptance can happen in the same cycle; ordering is strictly FIFO.
- **Reset mid-operation:** in-flight operations are lost. No out_valid appears for them.

## Test plan
- **Unsigned max and mode dependence (WIDTH=32):**
  - in_signed=0, a=b=0xFFFFFFFF, tag=3 → out_prod=0xFFFFFFFE00000001, out_tag=3, out_valid exactly 2 cycles after accept.
  - Same operands with in_signed=1 → out_prod=0x0000000000000001.
- **Signed corners:**
  - 0x80000000×0x80000000 → 0x4000000000000000.
  - 0xFFFFFFFF×0x00000005 → 0xFFFFFFFFFFFFFFFB.
  - 0x7FFFFFFF×0x80000000 → 0xC000000080000000.
- **Back-to-back:** 4 consecutive accepts (tags 0..3) with out_ready=1 → out_valid high 4 consecutive cycles, products and tags in order, in_ready never drops.
- **Backpressure:** out_ready=0 for 4 cycles while offering 3 ops → 2 ops held and in_ready=0 from cycle 3. Then out_ready=1 → all 3 delivered in order, once each.
- **Flush:** both stages full and in_valid=1, assert flush for one cycle → out_valid=0 and in_ready=0 in that cycle, pipeline empty next cycle, the offered op not accepted. The next op after flush has normal 2-cycle latency.
- **Reset:** assert reset with both stages valid and flush=1 → next cycle out_valid=0, out_prod=0, in_ready=1. Then a random signed/unsigned sweep of 10k ops is checked against a reference model.

Source files
------------

// File: rtl/mul_pipe_if.sv
// Operand/result bundle between the issue stage, mul_pipe and writeback.
// The master side drives operands and out_ready; the slave side is the multiplier.
interface mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/mul_pipe.sv
// Two-stage radix-4 Booth / Wallace-tree multiplier with valid/ready flow control.
// M1 compresses the Booth rows down to at most four; M2 finishes to two rows and adds them.
module mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic      mul_clk,
    input  logic      reset,
    input  logic      flush,
    mul_pipe_if.slave bus
);
    localparam int P   = 2 * WIDTH;
    localparam int E   = WIDTH + 2;
    localparam int NPP = WIDTH / 2 + 1;
    localparam int N0  = NPP + 2;

    function automatic int rows_at(input int n0, input int lvl);
        int n;
        n = n0;
        for (int k = 0; k < lvl; k++) begin
            n = (n / 3) * 2 + n % 3;
        end
        return n;
    endfunction

    function automatic int levels_to(input int n0, input int target);
        int n;
        int l;
        n = n0;
        l = 0;
        for (int k = 0; k < 64; k++) begin
            if (n > target) begin
                n = (n / 3) * 2 + n % 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    // Each row stores its sign as ~s at bit E+2j; this folds the matching -2^(E+2j) terms.
    function automatic logic [P-1:0] se_const();
        logic [P-1:0] c;
        logic [P-1:0] one;
        c   = '0;
        one = {{(P-1){1'b0}}, 1'b1};
        for (int j = 0; j < NPP; j++) begin
            if (E + 2 * j < P) begin
                c = c - (one << (E + 2 * j));
            end
        end
        return c;
    endfunction

    localparam int            M1_LEV   = levels_to(N0, 4);
    localparam int            N1       = rows_at(N0, M1_LEV);
    localparam int            M2_LEV   = levels_to(N1, 2);
    localparam logic [P-1:0]  SE_CONST = se_const();

    logic m1_valid_reg;
    logic m2_valid_reg;
    logic m2_allowin;
    logic m1_allowin;
    logic accept;
    logic m1_to_m2;

    logic [P-1:0]     m1_row_reg [N1];
    logic [TAG_W-1:0] m1_tag_reg;
    logic [P-1:0]     m2_prod_reg;
    logic [TAG_W-1:0] m2_tag_reg;

    assign m2_allowin    = !m2_valid_reg || bus.out_ready;
    assign m1_allowin    = !m1_valid_reg || m2_allowin;
    assign bus.in_ready  = m1_allowin && !flush;
    assign bus.out_valid = m2_valid_reg && !flush;
    assign bus.out_prod  = m2_prod_reg;
    assign bus.out_tag   = m2_tag_reg;
    assign accept        = bus.in_valid && bus.in_ready;
    assign m1_to_m2      = m1_valid_reg && m2_allowin;

    logic [E-1:0]   a_ext;
    logic [E-1:0]   b_ext;
    logic [E:0]     b_pad;
    logic [NPP-1:0] neg;
    logic [P-1:0]   corr_row;
    logic [P-1:0]   pp_rows [N0];

    assign a_ext = {{2{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
    assign b_ext = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b};
    assign b_pad = {b_ext, 1'b0};

    for (genvar gi = 0; gi < NPP; gi++) begin : g_booth
        logic [2:0] grp;
        logic       one;
        logic       two;
        logic [E:0] mag;
        logic [E:0] x;

        assign grp     = b_pad[2*gi +: 3];
        assign one     = grp[1] ^ grp[0];
        assign two     = (grp == 3'b011) || (grp == 3'b100);
        assign neg[gi] = grp[2] & ~(grp[1] & grp[0]);
        assign mag     = one ? {a_ext[E-1], a_ext} : (two ? {a_ext, 1'b0} : '0);
        // Negative digits use the one's complement here; the +1 lives in corr_row.
        assign x           = neg[gi] ? ~mag : mag;
        assign pp_rows[gi] = P'({~x[E], x[E-1:0]}) << (2 * gi);
    end

    always_comb begin
        corr_row = '0;
        for (int j = 0; j < NPP; j++) begin
            corr_row[2*j] = neg[j];
        end
    end

    assign pp_rows[NPP]     = corr_row;
    assign pp_rows[NPP + 1] = SE_CONST;

    // M1 Wallace levels: 3:2 compress each full triple, pass leftovers through unchanged.
    logic [P-1:0] m1_rows [N1];

    always_comb begin
        logic [P-1:0] t [N0];
        logic [P-1:0] xa;
        logic [P-1:0] xb;
        logic [P-1:0] xc;
        xa = '0;
        xb = '0;
        xc = '0;
        for (int k = 0; k < N0; k++) begin
            t[k] = pp_rows[k];
        end
        for (int l = 0; l < M1_LEV; l++) begin
            for (int g = 0; g < N0 / 3; g++) begin
                if (g < rows_at(N0, l) / 3) begin
                    xa       = t[3*g];
                    xb       = t[3*g+1];
                    xc       = t[3*g+2];
                    t[2*g]   = xa ^ xb ^ xc;
                    t[2*g+1] = ((xa & xb) | (xa & xc) | (xb & xc)) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rows_at(N0, l) % 3) begin
                    t[2*(rows_at(N0, l)/3) + r] = t[3*(rows_at(N0, l)/3) + r];
                end
            end
        end
        for (int k = 0; k < N1; k++) begin
            m1_rows[k] = t[k];
        end
    end

    // M2: remaining levels down to two rows, then the carry-propagate add.
    logic [P-1:0] m2_sum;

    always_comb begin
        logic [P-1:0] t [N1];
        logic [P-1:0] xa;
        logic [P-1:0] xb;
        logic [P-1:0] xc;
        xa = '0;
        xb = '0;
        xc = '0;
        for (int k = 0; k < N1; k++) begin
            t[k] = m1_row_reg[k];
        end
        for (int l = 0; l < M2_LEV; l++) begin
            for (int g = 0; g < N1 / 3; g++) begin
                if (g < rows_at(N1, l) / 3) begin
                    xa       = t[3*g];
                    xb       = t[3*g+1];
                    xc       = t[3*g+2];
                    t[2*g]   = xa ^ xb ^ xc;
                    t[2*g+1] = ((xa & xb) | (xa & xc) | (xb & xc)) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rows_at(N1, l) % 3) begin
                    t[2*(rows_at(N1, l)/3) + r] = t[3*(rows_at(N1, l)/3) + r];
                end
            end
        end
        m2_sum = t[0] + t[1];
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            m1_valid_reg <= 1'b0;
            m2_valid_reg <= 1'b0;
            m1_tag_reg   <= '0;
            m2_prod_reg  <= '0;
            m2_tag_reg   <= '0;
            for (int k = 0; k < N1; k++) begin
                m1_row_reg[k] <= '0;
            end
        end else if (flush) begin
            m1_valid_reg <= 1'b0;
            m2_valid_reg <= 1'b0;
        end else begin
            if (m1_allowin) begin
                m1_valid_reg <= bus.in_valid;
            end
            if (accept) begin
                m1_tag_reg <= bus.in_tag;
                for (int k = 0; k < N1; k++) begin
                    m1_row_reg[k] <= m1_rows[k];
                end
            end
            if (m2_allowin) begin
                m2_valid_reg <= m1_valid_reg;
            end
            if (m1_to_m2) begin
                m2_prod_reg <= m2_sum;
                m2_tag_reg  <= m1_tag_reg;
            end
        end
    end
endmodule

// File: tb/tb_mul_pipe.sv
// Directed-vector and scoreboard bench for mul_pipe at WIDTH=32, TAG_W=5.
module tb_mul_pipe;
    logic mul_clk = 1'b0;
    logic reset   = 1'b1;
    logic flush   = 1'b0;

    always #5 mul_clk = ~mul_clk;

    mul_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();

    mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .mul_clk (mul_clk),
        .reset   (reset),
        .flush   (flush),
        .bus     (bus)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] prod;
        logic [4:0]  tag;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb [$];

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the edge, then account the handshakes the next edge will take.
    task automatic tick(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic ordy, input logic fl);
        exp_t e;
        @(posedge mul_clk);
        #1;
        bus.in_valid  = v;
        bus.in_signed = s;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_prod", bus.out_prod, e.prod);
                chk("sb_tag", {59'd0, bus.out_tag}, {59'd0, e.tag});
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e.prod = ref_mul(s, a, b);
            e.tag  = t;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        tick(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, ordy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        tick(1'b1, v.sgn, v.a, v.b, v.tag, 1'b1, 1'b0);
        chk($sformatf("vec%0d_in_ready", idx), bus.in_ready, 1);
        idle(1'b1);
        chk($sformatf("vec%0d_lat1_valid", idx), bus.out_valid, 0);
        idle(1'b1);
        chk($sformatf("vec%0d_lat2_valid", idx), bus.out_valid, 1);
        chk($sformatf("vec%0d_prod", idx), bus.out_prod, v.exp);
        chk($sformatf("vec%0d_tag", idx), {59'd0, bus.out_tag}, {59'd0, v.tag});
    endtask

    vec_t vecs [10];

    initial begin
        int sent;
        int cyc;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  64'hFFFFFFFE00000001};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  64'h0000000000000001};
        vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 5'd5,  64'h4000000000000000};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h00000005, 5'd6,  64'hFFFFFFFFFFFFFFFB};
        vecs[4] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 5'd7,  64'hC000000080000000};
        vecs[5] = '{1'b0, 32'h80000000, 32'h80000000, 5'd8,  64'h4000000000000000};
        vecs[6] = '{1'b0, 32'h00000000, 32'h12345678, 5'd9,  64'h0000000000000000};
        vecs[7] = '{1'b0, 32'h0000FFFF, 32'h00010001, 5'd10, 64'h00000000FFFFFFFF};
        vecs[8] = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 5'd11, 64'hFFFFFFFFFFFFFFFA};
        vecs[9] = '{1'b0, 32'h00000003, 32'h00000007, 5'd31, 64'h0000000000000015};

        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge mul_clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_prod", bus.out_prod, 0);
        chk("rst_out_tag", {59'd0, bus.out_tag}, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end
        idle(1'b1);

        // Back-to-back: four accepts, four consecutive outputs in order.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 32'd100 + i, 32'd3, 5'(i), 1'b1, 1'b0);
            chk($sformatf("b2b_in_ready%0d", i), bus.in_ready, 1);
            if (i == 2 || i == 3) begin
                chk($sformatf("b2b_valid%0d", i - 2), bus.out_valid, 1);
                chk($sformatf("b2b_tag%0d", i - 2), {59'd0, bus.out_tag}, 64'(i - 2));
            end
        end
        for (int i = 2; i < 4; i++) begin
            idle(1'b1);
            chk($sformatf("b2b_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("b2b_tag%0d", i), {59'd0, bus.out_tag}, 64'(i));
        end
        idle(1'b1);
        chk("b2b_drained", bus.out_valid, 0);

        // Backpressure: three ops offered while out_ready is low for four cycles.
        tick(1'b1, 1'b0, 32'd11, 32'd13, 5'd20, 1'b0, 1'b0);
        chk("bp_c1_in_ready", bus.in_ready, 1);
        tick(1'b1, 1'b1, 32'hFFFFFFF0, 32'd7, 5'd21, 1'b0, 1'b0);
        chk("bp_c2_in_ready", bus.in_ready, 1);
        tick(1'b1, 1'b0, 32'd1000, 32'd1000, 5'd22, 1'b0, 1'b0);
        chk("bp_c3_in_ready", bus.in_ready, 0);
        chk("bp_c3_prod", bus.out_prod, 64'd143);
        tick(1'b1, 1'b0, 32'd1000, 32'd1000, 5'd22, 1'b0, 1'b0);
        chk("bp_c4_in_ready", bus.in_ready, 0);
        chk("bp_c4_prod_stable", bus.out_prod, 64'd143);
        chk("bp_c4_tag_stable", {59'd0, bus.out_tag}, 64'd20);
        tick(1'b1, 1'b0, 32'd1000, 32'd1000, 5'd22, 1'b1, 1'b0);
        chk("bp_c5_in_ready", bus.in_ready, 1);
        idle(1'b1);
        chk("bp_out1_tag", {59'd0, bus.out_tag}, 64'd21);
        idle(1'b1);
        chk("bp_out2_tag", {59'd0, bus.out_tag}, 64'd22);
        chk("bp_out2_prod", bus.out_prod, 64'd1000000);
        idle(1'b1);
        chk("bp_done_valid", bus.out_valid, 0);
        chk("bp_sb_empty", 64'(sb.size()), 0);

        // Flush with both stages full and an op offered.
        tick(1'b1, 1'b0, 32'd5, 32'd6, 5'd10, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 32'd7, 32'd8, 5'd11, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 32'd9, 32'd9, 5'd12, 1'b0, 1'b0);
        chk("fl_full_in_ready", bus.in_ready, 0);
        tick(1'b1, 1'b0, 32'd9, 32'd9, 5'd12, 1'b1, 1'b1);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 0);
        sb.delete();
        idle(1'b1);
        chk("fl_next_valid", bus.out_valid, 0);
        chk("fl_next_in_ready", bus.in_ready, 1);
        idle(1'b1);
        chk("fl_not_accepted", bus.out_valid, 0);
        run_vec(vecs[4], 40);
        idle(1'b1);

        // Reset while both stages hold work and flush is high.
        tick(1'b1, 1'b0, 32'd123, 32'd456, 5'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 32'd789, 32'd321, 5'd2, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge mul_clk);
        #1;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        sb.delete();
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_prod", bus.out_prod, 0);
        chk("mrst_out_tag", {59'd0, bus.out_tag}, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        idle(1'b1);
        idle(1'b1);
        chk("mrst_no_ghost", bus.out_valid, 0);

        // Random signed/unsigned sweep with random bubbles and backpressure.
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
            tick((sent < 10000) && ($urandom_range(3) != 0), 1'($urandom), $urandom, $urandom,
                 5'($urandom), $urandom_range(3) != 0, 1'b0);
            if (bus.in_valid && bus.in_ready) begin
                sent++;
            end
            cyc++;
        end
        chk("sweep_complete", 64'(sent), 64'd10000);
        chk("sweep_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
